// File: rtl/extmem_ctrl.sv
// -----------------------------------------------------------------------------
// extmem_ctrl
//
// External memory controller between the cache controller's main-memory port
// and a 16-bit asynchronous SRAM. Each 32-bit word request is executed as a
// low-halfword access followed by a high-halfword access. Each strobe phase
// lasts WAIT+1 cycles. Writes honour byte enables, skip halves with no enabled
// lanes, and insert one recovery cycle after each write strobe.
//
// Ports
//   ph1        : clock; all state changes on its rising edge
//   reset      : synchronous, active-high reset
//   memadr     : 27-bit word address (latched at acceptance)
//   memdata    : 32-bit bidirectional data. Write data is taken in at
//                acceptance. Read data is driven only during the memdone cycle.
//   membyteen  : byte enables, used for writes only
//   memrwb     : 1 = read, 0 = write
//   memen      : request, held high by the requester until memdone is seen
//   memdone    : one-cycle completion pulse
//   sram_adr   : 28-bit halfword address
//   sram_din   : SRAM read data
//   sram_dout  : SRAM write data
//   sram_doe   : drive enable for the external dq pad
//   sram_ceb / sram_oeb / sram_web / sram_lbb / sram_ubb :
//                active-low chip, output, write, lower-byte and upper-byte
//                strobes
// -----------------------------------------------------------------------------
module extmem_ctrl #(
    parameter int WAIT = 2
) (
    input  logic        ph1,
    input  logic        reset,
    input  logic [26:0] memadr,
    inout  wire  [31:0] memdata,
    input  logic [3:0]  membyteen,
    input  logic        memrwb,
    input  logic        memen,
    output logic        memdone,
    output logic [27:0] sram_adr,
    input  logic [15:0] sram_din,
    output logic [15:0] sram_dout,
    output logic        sram_doe,
    output logic        sram_ceb,
    output logic        sram_oeb,
    output logic        sram_web,
    output logic        sram_lbb,
    output logic        sram_ubb
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    typedef enum logic [2:0] {
        IDLE,
        LO,
        LOREC,
        HI,
        HIREC,
        DONE,
        RELEASE
    } state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;

    // Request registers, captured once at acceptance.
    logic [26:0] adr_q;
    logic [31:0] data_q;
    logic [3:0]  be_q;
    logic        rwb_q;

    // Read halves assembled for the DONE cycle.
    logic [15:0] rdlo, rdhi;

    logic        accept;
    logic        phase_last;

    assign accept     = (state == IDLE) && memen;
    assign phase_last = (cnt == WAIT_CNT);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples values from before the edge, independent of statement
    // order.
    always_ff @(posedge ph1) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // NOTE: the request and read-data registers are deliberately left
    // unreset. Their contents are never observed before being written by an
    // accepted request, so resetting them would only add reset fan-out.
    always_ff @(posedge ph1) begin
        if (accept) begin
            adr_q  <= memadr;
            data_q <= memdata;
            be_q   <= membyteen;
            rwb_q  <= memrwb;
        end
        if (state == LO && rwb_q && phase_last) rdlo <= sram_din;
        if (state == HI && rwb_q && phase_last) rdhi <= sram_din;
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can leave one unassigned and infer a
    // latch.
    always_comb begin
        state_n = state;
        cnt_n   = '0;  // reload to 0 on every phase entry

        unique case (state)
            IDLE: begin
                if (memen) begin
                    if (memrwb)                   state_n = LO;
                    else if (membyteen == 4'b0000) state_n = DONE;
                    else if (membyteen[1:0] == 2'b00) state_n = HI;
                    else                          state_n = LO;
                end
            end
            LO: begin
                if (phase_last) state_n = rwb_q ? HI : LOREC;
                else            cnt_n   = cnt + 4'd1;
            end
            LOREC: begin
                state_n = (be_q[3:2] == 2'b00) ? DONE : HI;
            end
            HI: begin
                if (phase_last) state_n = rwb_q ? DONE : HIREC;
                else            cnt_n   = cnt + 4'd1;
            end
            HIREC:   state_n = DONE;
            DONE:    state_n = RELEASE;
            // Holding here until memen drops keeps a request that is still
            // asserted in the cycle after memdone from starting a second access.
            RELEASE: if (!memen) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode, from registered state and request fields only
    // -------------------------------------------------------------------------
    always_comb begin
        memdone   = 1'b0;
        sram_adr  = '0;
        sram_dout = '0;
        sram_doe  = 1'b0;
        sram_ceb  = 1'b1;
        sram_oeb  = 1'b1;
        sram_web  = 1'b1;
        sram_lbb  = 1'b1;
        sram_ubb  = 1'b1;

        unique case (state)
            LO, HI: begin
                sram_ceb = 1'b0;
                sram_adr = {adr_q, state == HI};
                if (rwb_q) begin
                    // Reads always fetch the full halfword.
                    sram_oeb = 1'b0;
                    sram_lbb = 1'b0;
                    sram_ubb = 1'b0;
                end else begin
                    sram_web  = 1'b0;
                    sram_doe  = 1'b1;
                    sram_dout = (state == HI) ? data_q[31:16] : data_q[15:0];
                    sram_lbb  = (state == HI) ? ~be_q[2] : ~be_q[0];
                    sram_ubb  = (state == HI) ? ~be_q[3] : ~be_q[1];
                end
            end
            LOREC, HIREC: begin
                // web released while address, data and lanes stay stable,
                // giving the SRAM its write-recovery time.
                sram_ceb  = 1'b0;
                sram_doe  = 1'b1;
                sram_adr  = {adr_q, state == HIREC};
                sram_dout = (state == HIREC) ? data_q[31:16] : data_q[15:0];
                sram_lbb  = (state == HIREC) ? ~be_q[2] : ~be_q[0];
                sram_ubb  = (state == HIREC) ? ~be_q[3] : ~be_q[1];
            end
            DONE:    memdone = 1'b1;
            default: ;
        endcase
    end

    assign memdata = (state == DONE && rwb_q) ? {rdhi, rdlo} : 32'bz;

endmodule
